// File: rtl/cpu_pkg.sv
// Shared types and constants for the pipeline hazard/stall controller.
// HAZARD_PERF_CNT_EN (when defined) enables perf counters and the mem_wait input.
package cpu_pkg;
  localparam int REG_W      = 5;
  localparam int DIV_CYCLES = 36;
  localparam int CNT_W      = 16;

  localparam logic [REG_W-1:0] REG_ZERO = '0;

  typedef enum logic {
    IDLE     = 1'b0,
    DIV_BUSY = 1'b1
  } div_state_t;

  // True when a producer register feeds either D-stage source; $0 never does.
  function automatic logic reg_hit(input logic [REG_W-1:0] wreg,
                                   input logic [REG_W-1:0] rs,
                                   input logic [REG_W-1:0] rt);
    return (wreg != REG_ZERO) && ((wreg == rs) || (wreg == rt));
  endfunction
endpackage

// File: rtl/hazard_stall_ctrl_if.sv
// Pipeline-side bundle of hazard inputs and stall/flush outputs.
// HAZARD_PERF_CNT_EN adds the mem_wait input.
interface hazard_stall_ctrl_if;
  import cpu_pkg::*;

  // No valid/ready here: every signal is a level sampled each cycle, and the
  // pipeline registers act on stall/flush at the next posedge.
  logic [REG_W-1:0] rs_d;
  logic [REG_W-1:0] rt_d;
  logic             branch_d;
  logic [REG_W-1:0] wreg_e;
  logic             regwrite_e;
  logic             memtoreg_e;
  logic [REG_W-1:0] wreg_m;
  logic             memtoreg_m;
  logic             div_start_e;
  logic             exc_m;
`ifdef HAZARD_PERF_CNT_EN
  logic             mem_wait;
`endif
  logic             stall_f;
  logic             stall_d;
  logic             stall_e;
  logic             stall_m;
  logic             flush_d;
  logic             flush_e;
  logic             flush_m;
  logic             flush_w;
  logic             div_busy;
  div_state_t       div_state;

  modport master (
    output rs_d, rt_d, branch_d, wreg_e, regwrite_e, memtoreg_e,
           wreg_m, memtoreg_m, div_start_e, exc_m,
`ifdef HAZARD_PERF_CNT_EN
           mem_wait,
`endif
    input  stall_f, stall_d, stall_e, stall_m,
           flush_d, flush_e, flush_m, flush_w, div_busy, div_state
  );

  modport slave (
    input  rs_d, rt_d, branch_d, wreg_e, regwrite_e, memtoreg_e,
           wreg_m, memtoreg_m, div_start_e, exc_m,
`ifdef HAZARD_PERF_CNT_EN
           mem_wait,
`endif
    output stall_f, stall_d, stall_e, stall_m,
           flush_d, flush_e, flush_m, flush_w, div_busy, div_state
  );
endinterface

// File: rtl/div_occupancy_fsm.sv
// Tracks E-stage occupancy of a multi-cycle divide: DIV_CYCLES cycles total,
// with div_busy high in all but the last one.
module div_occupancy_fsm
  import cpu_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       div_start,
  input  logic       exc,
  output logic       div_busy,
  output div_state_t state
);
  localparam int              CW   = (DIV_CYCLES > 2) ? $clog2(DIV_CYCLES) : 1;
  localparam logic [CW-1:0]   LOAD = CW'(DIV_CYCLES - 2);

  div_state_t    state_next;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_next;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // An exception aborts the divide and masks a same-cycle start.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    div_busy   = 1'b0;
    if (exc) begin
      state_next = IDLE;
      cnt_next   = '0;
    end else begin
      case (state)
        IDLE: begin
          if (div_start) begin
            state_next = DIV_BUSY;
            cnt_next   = LOAD;
            div_busy   = 1'b1;
          end
        end
        DIV_BUSY: begin
          if (cnt == '0) begin
            state_next = IDLE;
          end else begin
            cnt_next = cnt - 1'b1;
            div_busy = 1'b1;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end
endmodule

// File: rtl/hazard_stall_ctrl.sv
// Central stall/flush generator for the 5-stage pipeline.
// HAZARD_PERF_CNT_EN adds saturating stall counters and the mem_wait path.
module hazard_stall_ctrl
  import cpu_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  hazard_stall_ctrl_if.slave hz
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] lu_stall_cnt,
  output logic [CNT_W-1:0] br_stall_cnt,
  output logic [CNT_W-1:0] div_stall_cnt
`endif
);
  logic       lw_stall;
  logic       br_stall;
  logic       dec_stall;
  logic       busy_raw;
  div_state_t div_state;

  assign lw_stall  = hz.memtoreg_e & hz.regwrite_e & reg_hit(hz.wreg_e, hz.rs_d, hz.rt_d);
  assign br_stall  = hz.branch_d &
                     ((hz.regwrite_e & reg_hit(hz.wreg_e, hz.rs_d, hz.rt_d)) |
                      (hz.memtoreg_m & reg_hit(hz.wreg_m, hz.rs_d, hz.rt_d)));
  assign dec_stall = lw_stall | br_stall;

  div_occupancy_fsm u_div (
    .clk       (clk),
    .rst       (rst),
    .div_start (hz.div_start_e),
    .exc       (hz.exc_m),
    .div_busy  (busy_raw),
    .state     (div_state)
  );

  assign hz.div_state = div_state;

  // Priority: reset, exception, memory wait, divide hold, decode bubble.
  always_comb begin
    hz.stall_f  = 1'b0;
    hz.stall_d  = 1'b0;
    hz.stall_e  = 1'b0;
    hz.stall_m  = 1'b0;
    hz.flush_d  = 1'b0;
    hz.flush_e  = 1'b0;
    hz.flush_m  = 1'b0;
    hz.flush_w  = 1'b0;
    hz.div_busy = rst & busy_raw;
    if (rst) begin
      if (hz.exc_m) begin
        hz.flush_d = 1'b1;
        hz.flush_e = 1'b1;
        hz.flush_m = 1'b1;
        hz.flush_w = 1'b1;
      end
`ifdef HAZARD_PERF_CNT_EN
      else if (hz.mem_wait) begin
        hz.stall_f = 1'b1;
        hz.stall_d = 1'b1;
        hz.stall_e = 1'b1;
        hz.stall_m = 1'b1;
        hz.flush_w = 1'b1;
      end
`endif
      else if (busy_raw) begin
        hz.stall_f = 1'b1;
        hz.stall_d = 1'b1;
        hz.stall_e = 1'b1;
        hz.flush_m = 1'b1;
      end else if (dec_stall) begin
        hz.stall_f = 1'b1;
        hz.stall_d = 1'b1;
        hz.flush_e = 1'b1;
      end
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lu_stall_cnt  <= '0;
      br_stall_cnt  <= '0;
      div_stall_cnt <= '0;
    end else begin
      if (lw_stall && !busy_raw && (lu_stall_cnt != '1))
        lu_stall_cnt <= lu_stall_cnt + 1'b1;
      if (br_stall && !busy_raw && (br_stall_cnt != '1))
        br_stall_cnt <= br_stall_cnt + 1'b1;
      if (busy_raw && (div_stall_cnt != '1))
        div_stall_cnt <= div_stall_cnt + 1'b1;
    end
  end
`endif
endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Self-checking bench for hazard_stall_ctrl: directed scenarios plus a
// randomized run against a cycle-level behavioural model.
module tb_hazard_stall_ctrl;
  import cpu_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   total = 0;
  int   bad   = 0;
  int   occ   = 0;   // remaining E-stage cycles of the divide in flight, 0 = none

  hazard_stall_ctrl_if hz ();

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] lu_cnt, br_cnt, dv_cnt;
  hazard_stall_ctrl dut (.clk(clk), .rst(rst), .hz(hz),
                         .lu_stall_cnt(lu_cnt), .br_stall_cnt(br_cnt), .div_stall_cnt(dv_cnt));
`else
  hazard_stall_ctrl dut (.clk(clk), .rst(rst), .hz(hz));
`endif

  always #5 clk = ~clk;

  // Vector order: {stall_f,stall_d,stall_e,stall_m,flush_d,flush_e,flush_m,flush_w,div_busy}
  localparam logic [8:0] V_ZERO   = 9'b0000_0000_0;
  localparam logic [8:0] V_BUBBLE = 9'b1100_0100_0;
  localparam logic [8:0] V_DIV    = 9'b1110_0010_1;
  localparam logic [8:0] V_EXC    = 9'b0000_1111_0;

  function automatic logic [8:0] dut_vec();
    return {hz.stall_f, hz.stall_d, hz.stall_e, hz.stall_m,
            hz.flush_d, hz.flush_e, hz.flush_m, hz.flush_w, hz.div_busy};
  endfunction

  function automatic logic uses(input logic [REG_W-1:0] w);
    return (w != 0) && (w == hz.rs_d || w == hz.rt_d);
  endfunction

  function automatic logic [8:0] model_out();
    logic lw, br, busy;
    if (!rst) return V_ZERO;
    if (hz.exc_m) return V_EXC;
    lw = hz.memtoreg_e && hz.regwrite_e && uses(hz.wreg_e);
    br = hz.branch_d && ((hz.regwrite_e && uses(hz.wreg_e)) || (hz.memtoreg_m && uses(hz.wreg_m)));
    busy = (occ == 0) ? hz.div_start_e : (occ > 1);
    if (busy) return V_DIV;
    if (lw || br) return V_BUBBLE;
    return V_ZERO;
  endfunction

  task automatic model_tick();
    if (!rst || hz.exc_m) occ = 0;
    else if (occ == 0 && hz.div_start_e) occ = DIV_CYCLES - 1;
    else if (occ > 0) occ = occ - 1;
  endtask

  task automatic set_idle();
    hz.rs_d = '0; hz.rt_d = '0; hz.branch_d = 1'b0;
    hz.wreg_e = '0; hz.regwrite_e = 1'b0; hz.memtoreg_e = 1'b0;
    hz.wreg_m = '0; hz.memtoreg_m = 1'b0;
    hz.div_start_e = 1'b0; hz.exc_m = 1'b0;
`ifdef HAZARD_PERF_CNT_EN
    hz.mem_wait = 1'b0;
`endif
  endtask

  task automatic set_load_use();
    hz.memtoreg_e = 1'b1; hz.regwrite_e = 1'b1; hz.wreg_e = 5'd8; hz.rs_d = 5'd8;
  endtask

  // Advance one clock: model follows the posedge, inputs change at negedge.
  task automatic adv();
    @(posedge clk);
    model_tick();
    @(negedge clk);
  endtask

  task automatic test_reset();
    logic [8:0] got;
    set_idle();
    set_load_use();
    hz.div_start_e = 1'b1;
    #1 got = dut_vec();
    total++;
    if (got !== V_ZERO) begin bad++; $display("FAIL reset_outputs: got=%b exp=%b", got, V_ZERO); end
    @(negedge clk);
    rst = 1'b1;
    set_idle();
    occ = 0;
    #1 total++;
    if (hz.div_state !== IDLE) begin bad++; $display("FAIL reset_state: got=%0d exp=%0d", hz.div_state, IDLE); end
    adv();
  endtask

  task automatic test_load_use();
    logic [8:0] got;
    set_idle();
    set_load_use();
    #1 got = dut_vec();
    total++;
    if (got !== V_BUBBLE) begin bad++; $display("FAIL load_use_stall: got=%b exp=%b", got, V_BUBBLE); end
    adv();
    set_idle();
    hz.rs_d = 5'd8; hz.memtoreg_m = 1'b1; hz.wreg_m = 5'd8;
    #1 got = dut_vec();
    total++;
    if (got !== V_ZERO) begin bad++; $display("FAIL load_use_after: got=%b exp=%b", got, V_ZERO); end
    adv();
  endtask

  task automatic test_zero_reg();
    logic [8:0] got;
    set_idle();
    hz.memtoreg_e = 1'b1; hz.regwrite_e = 1'b1; hz.wreg_e = '0;
    hz.branch_d = 1'b1; hz.memtoreg_m = 1'b1; hz.wreg_m = '0;
    #1 got = dut_vec();
    total++;
    if (got !== V_ZERO) begin bad++; $display("FAIL zero_reg: got=%b exp=%b", got, V_ZERO); end
    adv();
  endtask

  task automatic test_branch();
    logic [8:0] got;
    set_idle();
    hz.branch_d = 1'b1; hz.rs_d = 5'd3; hz.regwrite_e = 1'b1; hz.wreg_e = 5'd3;
    #1 got = dut_vec();
    total++;
    if (got !== V_BUBBLE) begin bad++; $display("FAIL branch_e_stall: got=%b exp=%b", got, V_BUBBLE); end
    adv();
    set_idle();
    hz.branch_d = 1'b1; hz.rs_d = 5'd3; hz.wreg_m = 5'd3;
    #1 got = dut_vec();
    total++;
    if (got !== V_ZERO) begin bad++; $display("FAIL branch_after: got=%b exp=%b", got, V_ZERO); end
    adv();
    hz.rt_d = 5'd3; hz.rs_d = 5'd1; hz.memtoreg_m = 1'b1;
    #1 got = dut_vec();
    total++;
    if (got !== V_BUBBLE) begin bad++; $display("FAIL branch_m_load: got=%b exp=%b", got, V_BUBBLE); end
    adv();
  endtask

  task automatic test_divide();
    logic [8:0] got, exp;
    int busy_n = 0;
    set_idle();
    set_load_use();
    hz.div_start_e = 1'b1;
    for (int i = 0; i < DIV_CYCLES + 4; i++) begin
      if (i == 1) hz.div_start_e = 1'b0;
      #1 got = dut_vec(); exp = model_out();
      if (got[0]) busy_n++;
      total++;
      if (got !== exp) begin bad++; $display("FAIL divide_cycle%0d: got=%b exp=%b", i, got, exp); end
      adv();
    end
    total++;
    if (busy_n != DIV_CYCLES - 1) begin bad++; $display("FAIL divide_busy_len: got=%0d exp=%0d", busy_n, DIV_CYCLES - 1); end
  endtask

  task automatic test_exc_mid_divide();
    logic [8:0] got, exp;
    set_idle();
    hz.div_start_e = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (i == 1) hz.div_start_e = 1'b0;
      #1 got = dut_vec(); exp = model_out();
      total++;
      if (got !== exp) begin bad++; $display("FAIL exc_pre%0d: got=%b exp=%b", i, got, exp); end
      adv();
    end
    hz.exc_m = 1'b1;
    #1 got = dut_vec();
    total++;
    if (got !== V_EXC) begin bad++; $display("FAIL exc_flush: got=%b exp=%b", got, V_EXC); end
    adv();
    hz.exc_m = 1'b0;
    #1 got = dut_vec();
    total++;
    if (got !== V_ZERO || hz.div_state !== IDLE) begin
      bad++; $display("FAIL exc_after: got=%b/%0d exp=%b/%0d", got, hz.div_state, V_ZERO, IDLE);
    end
    adv();
  endtask

  task automatic test_async_reset();
    logic [8:0] got, exp;
    int busy_n = 0;
    set_idle();
    hz.div_start_e = 1'b1;
    adv();
    hz.div_start_e = 1'b0;
    repeat (4) adv();
    set_load_use();
    #2 rst = 1'b0;
    occ = 0;
    #1 got = dut_vec();
    total++;
    if (got !== V_ZERO) begin bad++; $display("FAIL async_reset_out: got=%b exp=%b", got, V_ZERO); end
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    set_idle();
    hz.div_start_e = 1'b1;
    for (int i = 0; i < DIV_CYCLES + 3; i++) begin
      if (i == 1) hz.div_start_e = 1'b0;
      #1 got = dut_vec(); exp = model_out();
      if (got[0]) busy_n++;
      total++;
      if (got !== exp) begin bad++; $display("FAIL rediv_cycle%0d: got=%b exp=%b", i, got, exp); end
      adv();
    end
    total++;
    if (busy_n != DIV_CYCLES - 1) begin bad++; $display("FAIL rediv_busy_len: got=%0d exp=%0d", busy_n, DIV_CYCLES - 1); end
  endtask

  task automatic test_random();
    logic [8:0] got, exp;
    for (int i = 0; i < 800; i++) begin
      hz.rs_d        = REG_W'($urandom_range(0, 3));
      hz.rt_d        = REG_W'($urandom_range(0, 3));
      hz.wreg_e      = REG_W'($urandom_range(0, 3));
      hz.wreg_m      = REG_W'($urandom_range(0, 3));
      hz.branch_d    = ($urandom_range(0, 2) == 0);
      hz.regwrite_e  = $urandom_range(0, 1);
      hz.memtoreg_e  = $urandom_range(0, 1);
      hz.memtoreg_m  = $urandom_range(0, 1);
      hz.div_start_e = ($urandom_range(0, 15) == 0);
      hz.exc_m       = ($urandom_range(0, 40) == 0);
      #1 got = dut_vec(); exp = model_out();
      total++;
      if (got !== exp) begin bad++; $display("FAIL random%0d: got=%b exp=%b", i, got, exp); end
      adv();
    end
  endtask

  initial begin
    set_idle();
    @(negedge clk);
    test_reset();
    test_load_use();
    test_zero_reg();
    test_branch();
    test_divide();
    test_exc_mid_divide();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
